// File: rtl/timer_pkg.sv
// ============================================================================
// timer_pkg : shared state encoding and default widths for mod_down_timer
// Revision  : 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

    localparam int C_DEF_WIDTH  = 3;
    localparam int C_DEF_WCNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mod_down_core.sv
// ============================================================================
// mod_down_core : down-count datapath with reload register, zero detect,
//                 terminal-count pulse and saturating wrap counter
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mod_down_core
    import timer_pkg::*;
#(
    parameter int WIDTH  = C_DEF_WIDTH,
    parameter int WCNT_W = C_DEF_WCNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              tick,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              auto_reload,
    output logic [WIDTH-1:0]  count,
    output logic [WCNT_W-1:0] wrap_cnt,
    output logic              tc,
    output logic              last,
    output logic              mode
);

    localparam logic [WIDTH-1:0]  C_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0]  C_ZERO  = '0;
    localparam logic [WCNT_W-1:0] C_WONE  = WCNT_W'(1);

    logic [WIDTH-1:0]  r_count;
    logic [WIDTH-1:0]  r_reload;
    logic [WCNT_W-1:0] r_wrap;
    logic              r_mode;
    logic              r_tc;
    logic              w_last;

    assign w_last = (r_count == C_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_reload <= '0;
            r_wrap   <= '0;
            r_mode   <= 1'b0;
            r_tc     <= 1'b0;
        end else if (load) begin
            r_count  <= load_val;
            r_reload <= load_val;
            r_mode   <= auto_reload;
            r_wrap   <= '0;
            r_tc     <= 1'b0;
        end else begin
            // tc marks the first cycle count shows 0 after a 1->0 step
            r_tc <= tick & w_last;
            if (tick) begin
                if (r_count == C_ZERO) begin
                    if (r_mode) begin
                        r_count <= r_reload;
                        if (!(&r_wrap)) begin
                            r_wrap <= r_wrap + C_WONE;
                        end
                    end
                end else begin
                    r_count <= r_count - C_ONE;
                end
            end
        end
    end

    assign count    = r_count;
    assign wrap_cnt = r_wrap;
    assign tc       = r_tc;
    assign last     = w_last;
    assign mode     = r_mode;

endmodule

`default_nettype wire

// File: rtl/mod_down_timer.sv
// ============================================================================
// mod_down_timer : start/stop controlled modulo down-timer, one-shot or
//                  periodic, with terminal-count and illegal-start reporting
// Revision       : 1.0
// ============================================================================
`default_nettype none

module mod_down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH  = C_DEF_WIDTH,
    parameter int WCNT_W = C_DEF_WCNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              en,
    input  logic              auto_reload,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              tc,
    output logic              done,
    output logic              err,
    output logic [WCNT_W-1:0] wrap_cnt
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_err;
    logic   w_err_nxt;
    logic   w_load;
    logic   w_tick;
    logic   w_last;
    logic   w_mode;

    mod_down_core #(
        .WIDTH  (WIDTH),
        .WCNT_W (WCNT_W)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (w_load),
        .tick        (w_tick),
        .load_val    (load_val),
        .auto_reload (auto_reload),
        .count       (count),
        .wrap_cnt    (wrap_cnt),
        .tc          (tc),
        .last        (w_last),
        .mode        (w_mode)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        w_load      = 1'b0;
        w_tick      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (load_val != '0) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // stop outranks start and the tick; start is ignored here
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (en) begin
                    w_tick = 1'b1;
                    if (w_last && !w_mode) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mod_down_timer.sv
// ============================================================================
// tb_mod_down_timer : directed self-checking bench for mod_down_timer (WIDTH=3)
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_mod_down_timer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       en;
    logic       auto_reload;
    logic [2:0] load_val;
    logic [2:0] count;
    logic       busy;
    logic       tc;
    logic       done;
    logic       err;
    logic [3:0] wrap_cnt;
    logic [3:0] flags;

    int total;
    int bad;

    mod_down_timer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .en          (en),
        .auto_reload (auto_reload),
        .load_val    (load_val),
        .count       (count),
        .busy        (busy),
        .tc          (tc),
        .done        (done),
        .err         (err),
        .wrap_cnt    (wrap_cnt)
    );

    // flags = {busy, done, tc, err}
    assign flags = {busy, done, tc, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0;
        auto_reload = 1'b0; load_val = 3'd0;
        #12;
        total++;
        if (count !== 3'd0 || flags !== 4'b0000 || wrap_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset: count=%0d flags=%b wrap=%0d, want 0 0000 0", count, flags, wrap_cnt);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reload();
        logic [2:0] exp;
        start = 1'b1; load_val = 3'd7; auto_reload = 1'b1; en = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (count !== 3'd7 || flags !== 4'b1000 || wrap_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reload_load: count=%0d flags=%b wrap=%0d, want 7 1000 0", count, flags, wrap_cnt);
        end
        for (int i = 6; i >= 0; i--) begin
            step();
            exp = 3'(i);
            total++;
            if (count !== exp || tc !== (i == 0) || busy !== 1'b1) begin
                bad++;
                $display("FAIL reload_dec: count=%0d tc=%b busy=%b, want %0d %b 1", count, tc, busy, exp, (i == 0));
            end
        end
        step();
        total++;
        if (count !== 3'd7 || wrap_cnt !== 4'd1 || flags !== 4'b1000) begin
            bad++;
            $display("FAIL reload_wrap: count=%0d wrap=%0d flags=%b, want 7 1 1000", count, wrap_cnt, flags);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        total++;
        if (count !== 3'd7 || flags !== 4'b0000) begin
            bad++;
            $display("FAIL reload_stop: count=%0d flags=%b, want 7 0000", count, flags);
        end
    endtask

    task automatic test_oneshot();
        logic [2:0] exp_cnt [5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        logic [3:0] exp_flg [5] = '{4'b1000, 4'b1000, 4'b1000, 4'b0110, 4'b0100};
        start = 1'b1; load_val = 3'd3; auto_reload = 1'b0; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            start = 1'b0;
            total++;
            if (count !== exp_cnt[i] || flags !== exp_flg[i]) begin
                bad++;
                $display("FAIL oneshot[%0d]: count=%0d flags=%b, want %0d %b", i, count, flags, exp_cnt[i], exp_flg[i]);
            end
        end
    endtask

    task automatic test_enable();
        logic       en_seq  [3] = '{1'b1, 1'b0, 1'b1};
        logic [2:0] exp_cnt [3] = '{3'd4, 3'd4, 3'd3};
        start = 1'b1; load_val = 3'd5; auto_reload = 1'b0; en = 1'b0;
        step();
        start = 1'b0;
        total++;
        if (count !== 3'd5 || flags !== 4'b1000) begin
            bad++;
            $display("FAIL enable_load: count=%0d flags=%b, want 5 1000", count, flags);
        end
        for (int i = 0; i < 3; i++) begin
            en = en_seq[i];
            step();
            total++;
            if (count !== exp_cnt[i] || busy !== 1'b1) begin
                bad++;
                $display("FAIL enable[%0d]: count=%0d busy=%b, want %0d 1", i, count, busy, exp_cnt[i]);
            end
        end
        en = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_start_stop();
        start = 1'b1; load_val = 3'd6; auto_reload = 1'b1; en = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        total++;
        if (count !== 3'd4 || busy !== 1'b1) begin
            bad++;
            $display("FAIL ss_setup: count=%0d busy=%b, want 4 1", count, busy);
        end
        start = 1'b1; stop = 1'b1; load_val = 3'd2;
        step();
        start = 1'b0; stop = 1'b0;
        total++;
        if (count !== 3'd4 || flags !== 4'b0000) begin
            bad++;
            $display("FAIL ss_same_cycle: count=%0d flags=%b, want 4 0000", count, flags);
        end
        step();
        total++;
        if (count !== 3'd4 || flags !== 4'b0000) begin
            bad++;
            $display("FAIL ss_hold: count=%0d flags=%b, want 4 0000", count, flags);
        end
    endtask

    task automatic test_zero_start();
        start = 1'b1; load_val = 3'd0; en = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (count !== 3'd4 || flags !== 4'b0001) begin
            bad++;
            $display("FAIL zero_err: count=%0d flags=%b, want 4 0001", count, flags);
        end
        step();
        total++;
        if (count !== 3'd4 || flags !== 4'b0000) begin
            bad++;
            $display("FAIL zero_after: count=%0d flags=%b, want 4 0000", count, flags);
        end
    endtask

    task automatic test_start_in_run();
        start = 1'b1; load_val = 3'd7; auto_reload = 1'b0; en = 1'b0;
        step();
        start = 1'b1; load_val = 3'd2; auto_reload = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (count !== 3'd7 || flags !== 4'b1000) begin
            bad++;
            $display("FAIL run_restart: count=%0d flags=%b, want 7 1000", count, flags);
        end
        // latched one-shot mode must survive the auto_reload change above
        en = 1'b1;
        for (int i = 0; i < 7; i++) step();
        total++;
        if (count !== 3'd0 || flags !== 4'b0110) begin
            bad++;
            $display("FAIL run_latched: count=%0d flags=%b, want 0 0110", count, flags);
        end
    endtask

    task automatic test_mid_reset();
        start = 1'b1; load_val = 3'd7; auto_reload = 1'b1; en = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (count !== 3'd0 || flags !== 4'b0000 || wrap_cnt !== 4'd0) begin
            bad++;
            $display("FAIL mid_reset: count=%0d flags=%b wrap=%0d, want 0 0000 0", count, flags, wrap_cnt);
        end
        #3;
        rst_n = 1'b1;
        start = 1'b1; load_val = 3'd2;
        step();
        start = 1'b0;
        total++;
        if (count !== 3'd2 || flags !== 4'b1000) begin
            bad++;
            $display("FAIL post_reset_start: count=%0d flags=%b, want 2 1000", count, flags);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_reload();
        test_oneshot();
        test_enable();
        test_start_stop();
        test_zero_start();
        test_start_in_run();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mod_down_timer.md
MOD_DOWN_TIMER -- requirements
Module: mod_down_timer

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 3, as the count width (mod-8 at default).
REQ-002 The block SHALL provide parameter WCNT_W, default 4, as the wrap-counter width.
REQ-003 The block SHALL provide port clk, input, 1, system clock; all state changes on its rising edge.
REQ-004 The block SHALL provide port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL provide port start, input, 1, single-cycle request to load load_val and begin counting.
REQ-006 The block SHALL provide port stop, input, 1, single-cycle abort request.
REQ-007 The block SHALL provide port en, input, 1, tick enable; decrement only in cycles where en=1.
REQ-008 The block SHALL provide port auto_reload, input, 1, sampled at start; 1=periodic, 0=one-shot.
REQ-009 The block SHALL provide port load_val, input, WIDTH, sampled at start into an internal reload register.
REQ-010 The block SHALL provide port count, output, WIDTH, current count value.
REQ-011 The block SHALL provide port busy, output, 1, high in RUN.
REQ-012 The block SHALL provide port tc, output, 1, one-cycle terminal-count pulse.
REQ-013 The block SHALL provide port done, output, 1, level, high in DONE.
REQ-014 The block SHALL provide port err, output, 1, one-cycle pulse on an illegal start.
REQ-015 The block SHALL provide port wrap_cnt, output, WCNT_W, number of reloads since start, saturating.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-017 In IDLE or DONE, start with load_val!=0 SHALL, at the next edge, latch load_val and mode, set count=load_val, clear wrap_cnt, and enter RUN.
REQ-018 Start with load_val=0 SHALL pulse err for one cycle, leave state and count unchanged.
REQ-019 In RUN with en=1 and count>1, count SHALL decrement by 1 per edge; with en=0, count SHALL hold.
REQ-020 In RUN with en=1 and count=1, next count SHALL be 0 and tc SHALL be high in that same cycle where count=0 first appears (registered, latency 1 from the enabling edge).
REQ-021 In RUN with en=1 and count=0 and auto_reload latched 1, count SHALL reload to the latched value, wrap_cnt SHALL increment, saturating at all-ones.
REQ-022 When count reaches 0 with auto_reload latched 0, FSM SHALL enter DONE in the same edge; count SHALL hold 0.
REQ-023 Stop in RUN SHALL enter IDLE at the next edge with count held at its current value, no tc.
REQ-024 start and stop asserted together: in RUN, stop SHALL win; in IDLE or DONE, start SHALL win.
REQ-025 start while in RUN SHALL be ignored (no restart, no err).
REQ-026 Latched load_val/mode SHALL NOT change during RUN regardless of input changes.
REQ-027 Arithmetic SHALL be unsigned, modulo 2^WIDTH; no count value outside 0..latched load_val.

Reset
REQ-028 rst_n=0 SHALL, asynchronously, force IDLE, count=0, busy=0, tc=0, done=0, err=0, wrap_cnt=0, reload register=0.
REQ-029 Reset asserted mid-RUN SHALL abort without tc; after release, the block SHALL respond to start on the first edge.

Structure
REQ-030 State encoding (IDLE/RUN/DONE) and default WIDTH SHALL live in shared package timer_pkg.
REQ-031 The decrement/reload/zero-detect datapath SHALL be one sub-module, mod_down_core; the FSM SHALL stay in mod_down_timer.

Verification (WIDTH=3)
REQ-032 Bench SHALL check: rst_n pulse low mid-count -> all outputs 0 immediately, IDLE.
REQ-033 Bench SHALL check: start, load_val=7, auto_reload=1, en=1 -> count 7,6,...,0,7; tc on each 0; wrap_cnt 1 after first reload.
REQ-034 Bench SHALL check: start, load_val=3, auto_reload=0 -> count 3,2,1,0; tc once; done=1, busy=0 thereafter.
REQ-035 Bench SHALL check: en toggling 1,0,1 from count 5 -> 4,4,3.
REQ-036 Bench SHALL check: start+stop same cycle in RUN at count 4 -> IDLE, count 4, no tc.
REQ-037 Bench SHALL check: start with load_val=0 -> err one cycle, state IDLE, count unchanged.
